// File: rtl/m2v_recon_block.sv
// Reconstruction stage after the IDCT: residual + prediction, clipped to 0..255,
// streamed out as pixel pairs through a small skid FIFO under a read-credit scheme.
module m2v_recon_block #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       softreset,
  output logic       ready_recon,
  input  logic       block_start,
  input  logic       blk_coded,
  input  logic       blk_intra,
  output logic       pixel_coded,
  output logic [4:0] pixel_addr,
  input  logic [8:0] pixel_data0,
  input  logic [8:0] pixel_data1,
  output logic [4:0] pred_addr,
  input  logic [7:0] pred_data0,
  input  logic [7:0] pred_data1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_addr,
  output logic       out_last,
  output logic [7:0] out_data0,
  output logic [7:0] out_data1,
  output logic [1:0] state_dbg
);

  // Handshake: a pair transfers on a rising edge where out_valid & out_ready;
  // out_valid never drops and the pair never changes until that transfer happens.

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic            intra_q;
  logic            rd_pend;
  logic [4:0]      rd_addr;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [20:0]     mem [FIFO_DEPTH];
  logic [20:0]     head;
  logic            pop;
  logic            issue;
  logic [CW:0]     credit;
  logic [7:0]      px0;
  logic [7:0]      px1;

  function automatic logic [7:0] recon(input logic coded, input logic intra,
                                       input logic [8:0] res, input logic [7:0] pred);
    logic [9:0] r;
    logic [9:0] p;
    logic [9:0] s;
    r = coded ? {res[8], res} : 10'd0;
    p = intra ? 10'd0 : {2'b00, pred};
    s = r + p;
    if (s[9])      return 8'h00;
    else if (s[8]) return 8'hff;
    else           return s[7:0];
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] ptr);
    return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_addr  = out_valid ? head[20:16] : 5'd0;
  assign out_data0 = out_valid ? head[15:8]  : 8'd0;
  assign out_data1 = out_valid ? head[7:0]   : 8'd0;
  assign out_last  = out_valid && (head[20:16] == 5'd31);
  assign pred_addr = pixel_addr;
  assign state_dbg = state;

  // A read may only launch if its data is guaranteed a FIFO slot on return.
  assign credit = {1'b0, count} + (CW+1)'(rd_pend) - (CW+1)'(pop);
  assign issue  = (state == RUN) && (credit < (CW+1)'(FIFO_DEPTH));

  assign px0 = recon(pixel_coded, intra_q, pixel_data0, pred_data0);
  assign px1 = recon(pixel_coded, intra_q, pixel_data1, pred_data1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ready_recon <= 1'b1;
      pixel_coded <= 1'b0;
      intra_q     <= 1'b0;
      pixel_addr  <= 5'd0;
      rd_pend     <= 1'b0;
      rd_addr     <= 5'd0;
    end else if (softreset) begin
      state       <= IDLE;
      ready_recon <= 1'b1;
      pixel_coded <= 1'b0;
      intra_q     <= 1'b0;
      pixel_addr  <= 5'd0;
      rd_pend     <= 1'b0;
      rd_addr     <= 5'd0;
    end else begin
      rd_pend <= issue;
      if (issue) rd_addr <= pixel_addr;
      case (state)
        IDLE: begin
          if (block_start) begin
            pixel_coded <= blk_coded;
            intra_q     <= blk_intra;
            pixel_addr  <= 5'd0;
            ready_recon <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (pixel_addr == 5'd31) state <= DRAIN;
            else                     pixel_addr <= pixel_addr + 5'd1;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            ready_recon <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (softreset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rd_pend) wr_ptr <= nxt(wr_ptr);
      if (pop)     rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(rd_pend) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible while count says so.
  always_ff @(posedge clk) begin
    if (rd_pend) mem[wr_ptr] <= {rd_addr, px0, px1};
  end

endmodule

// File: tb/tb_m2v_recon_block.sv
// Randomized bench for m2v_recon_block: memory responders for the IDCT and
// prediction ports, an arithmetic reference model and an in-order scoreboard.
module tb_m2v_recon_block;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       softreset = 1'b0;
  logic       ready_recon;
  logic       block_start = 1'b0;
  logic       blk_coded = 1'b0;
  logic       blk_intra = 1'b0;
  logic       pixel_coded;
  logic [4:0] pixel_addr;
  logic [8:0] pixel_data0 = '0;
  logic [8:0] pixel_data1 = '0;
  logic [4:0] pred_addr;
  logic [7:0] pred_data0 = '0;
  logic [7:0] pred_data1 = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_addr;
  logic       out_last;
  logic [7:0] out_data0;
  logic [7:0] out_data1;
  logic [1:0] state_dbg;

  m2v_recon_block #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .softreset(softreset), .ready_recon(ready_recon),
    .block_start(block_start), .blk_coded(blk_coded), .blk_intra(blk_intra),
    .pixel_coded(pixel_coded), .pixel_addr(pixel_addr),
    .pixel_data0(pixel_data0), .pixel_data1(pixel_data1),
    .pred_addr(pred_addr), .pred_data0(pred_data0), .pred_data1(pred_data1),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_last(out_last), .out_data0(out_data0), .out_data1(out_data1),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- environment state ----------------
  logic [8:0]  res0 [32];
  logic [8:0]  res1 [32];
  logic [7:0]  pr0  [32];
  logic [7:0]  pr1  [32];
  logic [20:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pop_cnt = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: reconstructed pixel from the block flags, residual and prediction.
  function automatic logic [7:0] ref_pix(input bit coded, input bit intra,
                                         input logic [8:0] res, input logic [7:0] pred);
    int s;
    s = (coded ? int'($signed(res)) : 0) + (intra ? 0 : int'(pred));
    if (s < 0)   return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  // IDCT and prediction buffers: one-cycle read latency.
  initial begin
    logic [4:0] a;
    logic [4:0] pa;
    forever begin
      @(posedge clk);
      a  = pixel_addr;
      pa = pred_addr;
      #1;
      pixel_data0 = res0[a];
      pixel_data1 = res1[a];
      pred_data0  = pr0[pa];
      pred_data1  = pr1[pa];
    end
  end

  // Consumer ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      else                    out_ready = 1'b0;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic        prev_stall;
    logic [4:0]  h_addr;
    logic [7:0]  h_d0;
    logic [7:0]  h_d1;
    logic [20:0] e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || softreset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_addr",  32'(out_addr),  32'(h_addr));
        check("hold_data0", 32'(out_data0), 32'(h_d0));
        check("hold_data1", 32'(out_data1), 32'(h_d1));
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_pair", 32'(out_addr), 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("pair_addr",  32'(out_addr),  32'(e[20:16]));
          check("pair_data0", 32'(out_data0), 32'(e[15:8]));
          check("pair_data1", 32'(out_data1), 32'(e[7:0]));
          check("pair_last",  32'(out_last),  32'(e[20:16] == 5'd31));
        end
      end
      prev_stall = out_valid && !out_ready;
      h_addr = out_addr;
      h_d0   = out_data0;
      h_d1   = out_data1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_random();
    for (int a = 0; a < 32; a++) begin
      res0[a] = 9'($urandom_range(0, 511));
      res1[a] = 9'($urandom_range(0, 511));
      pr0[a]  = 8'($urandom_range(0, 255));
      pr1[a]  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic fill_const(input int r0, input int r1, input int p0, input int p1);
    for (int a = 0; a < 32; a++) begin
      res0[a] = 9'(r0);
      res1[a] = 9'(r1);
      pr0[a]  = 8'(p0);
      pr1[a]  = 8'(p1);
    end
  endtask

  task automatic load_expected(input bit coded, input bit intra);
    for (int a = 0; a < 32; a++)
      exp_q.push_back({5'(a), ref_pix(coded, intra, res0[a], pr0[a]),
                              ref_pix(coded, intra, res1[a], pr1[a])});
  endtask

  // Pulses block_start for one cycle (cycle T); returns at the negedge of T+1.
  task automatic start_block(input bit coded, input bit intra);
    int i;
    i = 0;
    while (!ready_recon && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("ready_before_start", 32'(ready_recon), 32'd1);
    load_expected(coded, intra);
    @(posedge clk);
    #1;
    block_start = 1'b1;
    blk_coded   = coded;
    blk_intra   = intra;
    @(posedge clk);
    #1;
    block_start = 1'b0;
    blk_coded   = 1'($urandom_range(0, 1));
    blk_intra   = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("busy_after_start", 32'(ready_recon), 32'd0);
    check("pixel_coded",      32'(pixel_coded), 32'(coded));
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!(ready_recon && exp_q.size() == 0) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(ready_recon && exp_q.size() == 0), 32'd1);
  endtask

  // Waits until the monitor has seen `n` pops since `base`.
  task automatic wait_pops(input int base, input int n, input string tag);
    int i;
    i = 0;
    while ((pop_cnt - base) < n && i < 1000) begin
      @(negedge clk);
      #1;
      i++;
    end
    check(tag, 32'(pop_cnt - base), 32'(n));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},  32'(ready_recon), 32'd1);
    check({tag, "_pcoded"}, 32'(pixel_coded), 32'd0);
    check({tag, "_paddr"},  32'(pixel_addr),  32'd0);
    check({tag, "_praddr"}, 32'(pred_addr),   32'd0);
    check({tag, "_valid"},  32'(out_valid),   32'd0);
    check({tag, "_oaddr"},  32'(out_addr),    32'd0);
    check({tag, "_last"},   32'(out_last),    32'd0);
    check({tag, "_data"},   32'({out_data0, out_data1}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic [4:0] frozen;
    fill_const(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Coded inter block, +10 on pred 100, full-rate timing.
    rdy_mode = 0;
    fill_const(10, 10, 100, 100);
    start_block(1'b1, 1'b0);               // now at negedge of T+1
    check("t1_addr0", 32'(pixel_addr), 32'd0);
    @(negedge clk);                        // T+2
    check("t2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);                        // T+3
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_addr",  32'(out_addr),  32'd0);
    repeat (31) @(negedge clk);            // T+34
    check("t34_last", 32'(out_last),  32'd1);
    check("t34_addr", 32'(out_addr),  32'd31);
    @(negedge clk);                        // T+35
    check("t35_ready", 32'(ready_recon), 32'd1);
    check("t35_valid", 32'(out_valid),   32'd0);
    wait_done("blk_plain_done");

    // Clipping both ways: -256 + 100 -> 0, 255 + 200 -> 255.
    fill_const(9'h100, 255, 100, 200);
    start_block(1'b1, 1'b0);
    wait_done("blk_clip_done");

    // Intra: prediction ignored.
    fill_random();
    for (int a = 0; a < 32; a++) begin
      res0[a] = 9'h1fb;                    // -5
      res1[a] = 9'd200;
    end
    start_block(1'b1, 1'b1);
    wait_done("blk_intra_done");

    // Uncoded: residual port garbage must be ignored, pred ramp passes through.
    fill_random();
    for (int a = 0; a < 32; a++) begin
      pr0[a] = 8'(2 * a);
      pr1[a] = 8'(2 * a + 1);
    end
    start_block(1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("uncoded_pcoded_mid", 32'(pixel_coded), 32'd0);
    wait_done("blk_uncoded_done");

    // Backpressure from the third output for 10 cycles.
    fill_random();
    base = pop_cnt;
    start_block(1'b1, 1'b0);
    wait_pops(base, 2, "bp_reach_2");
    rdy_mode = 2;
    @(posedge clk);
    #2;
    frozen = pixel_addr;
    repeat (9) @(negedge clk);
    check("bp_addr_frozen", 32'(pixel_addr), 32'(frozen));
    check("bp_held_le_depth", 32'((int'(pixel_addr) - (pop_cnt - base)) <= DEPTH), 32'd1);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_no_pops", 32'(pop_cnt - base), 32'd2);
    rdy_mode = 0;
    wait_done("blk_bp_done");

    // Ignored block_start mid-run, then reset at pair 12.
    fill_random();
    base = pop_cnt;
    start_block(1'b1, 1'b0);
    wait_pops(base, 3, "ign_reach_3");
    @(posedge clk);
    #1;
    block_start = 1'b1;
    blk_coded   = 1'b0;
    blk_intra   = 1'b1;
    @(posedge clk);
    #1;
    block_start = 1'b0;
    check("ign_still_busy", 32'(ready_recon), 32'd0);
    wait_pops(base, 12, "rst_reach_12");
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset_vals("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("after_mid_reset");
    fill_random();
    start_block(1'b1, 1'b0);
    wait_done("blk_after_reset_done");

    // Softreset abort under random backpressure, then a fresh block.
    rdy_mode = 1;
    fill_random();
    base = pop_cnt;
    start_block(1'b1, 1'b0);
    wait_pops(base, 1 + $urandom_range(0, 25), "srst_reach");
    @(posedge clk);
    #1;
    softreset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check_reset_vals("softreset");
    #1;
    softreset = 1'b0;
    fill_random();
    start_block(1'b1, 1'b0);
    wait_done("blk_after_srst_done");

    // Random blocks with random consumer stalls.
    for (int b = 0; b < 6; b++) begin
      fill_random();
      start_block(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done("blk_rand_done");
    end

    rdy_mode = 0;
    repeat (5) @(negedge clk);
    check("final_idle_valid", 32'(out_valid), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
